// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one WIDTH-bit ripple-carry adder is reused across
// WORDS cycles, with the carry held in a register between chunks.

module mwa_rca #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);
  logic cy;

  // Carry is held in a loop variable so the chain is not a self-dependent vector.
  always_comb begin
    cy  = c_i;
    s_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
    end
    c_o = cy;
  end
endmodule

module multiword_add_seq #(
  parameter int WIDTH = 64,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in1,
  input  logic [WIDTH*WORDS-1:0] in2,
  input  logic                   ci,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   co
);
  localparam int N  = WIDTH * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, co_q, co_d;
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic            add_c;

  assign add_a = a_q[cnt_q*WIDTH +: WIDTH];
  assign add_b = b_q[cnt_q*WIDTH +: WIDTH];

  mwa_rca #(.WIDTH(WIDTH)) u_rca (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
    // Flush wins over accept and handshake; the last result stays visible.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          sum_d[cnt_q*WIDTH +: WIDTH] = add_s;
          carry_d = add_c;
          if (cnt_q == LAST) begin
            co_d    = add_c;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and randomized checks of multiword_add_seq at WIDTH=64, WORDS=4.

module tb_multiword_add_seq;
  localparam int WIDTH = 64;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in1 = '0;
  logic [N-1:0] in2 = '0;
  logic         ci = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         co;

  int checks = 0;
  int failures = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .ci        (ci),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // Presents operands on the next ready edge, then scrambles them during RUN.
  task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("ready_timeout", 0, 1);
    in_valid = 1'b1; in1 = a; in2 = b; ci = c;
    tick();
    in_valid = 1'b0; in1 = rnd(); in2 = rnd(); ci = $urandom_range(0, 1) != 0;
  endtask

  task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic c);
    int lat = 0;
    start(a, b, c);
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk({tag, "_lat"}, lat, WORDS);
    chk({tag, "_res"}, {co, sum}, ref_add(a, b, c));
  endtask

  task automatic release_res(input string tag, input int stall, input logic [N:0] exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold"}, {in_ready, out_valid, co, sum}, {2'b01, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] a, b;
    logic         c;
    ones = '1;

    #12;
    chk("reset", {in_ready, out_valid, co, sum}, {2'b10, {(N+1){1'b0}}});
    rst_n = 1'b1;

    run("ripple", ones, '0, 1'b1);
    release_res("ripple", 0, {1'b1, {N{1'b0}}});

    run("simple", N'(5), N'(3), 1'b0);
    release_res("simple", 0, {1'b0, N'(8)});

    run("chunkc", {{(N-WIDTH){1'b0}}, {WIDTH{1'b1}}}, N'(1), 1'b0);
    release_res("chunkc", 0, {1'b0, N'(1) << WIDTH});

    run("maxall", ones, ones, 1'b1);
    release_res("bp", 10, {(N+1){1'b1}});

    // Flush mid-RUN at cnt=2; the next op must not see the stale carry.
    start(ones, ones, 1'b1);
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_idle", {in_ready, out_valid}, 2'b10);
    run("postflush", N'(1), N'(1), 1'b0);
    release_res("postflush", 0, {1'b0, N'(2)});

    // Flush beats acceptance.
    in_valid = 1'b1; in1 = N'(7); in2 = N'(7); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vs_accept", {in_ready, out_valid}, 2'b10);

    // Flush beats the result handshake; the result stays on sum/co.
    run("fhs", N'(100), N'(23), 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_vs_hs", {in_ready, out_valid, co, sum}, {2'b10, 1'b0, N'(124)});

    // Asynchronous reset at cnt=1, checked before the next clock edge.
    start(ones, N'(1), 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {in_ready, out_valid, co, sum}, {2'b10, {(N+1){1'b0}}});
    #2 rst_n = 1'b1;
    run("postrst", N'(12345), N'(54321), 1'b1);
    release_res("postrst", 0, {1'b0, N'(66667)});

    for (int i = 0; i < 300; i++) begin
      a = rnd(); b = rnd(); c = $urandom_range(0, 1) != 0;
      if (i % 7 == 0) a = ones;
      run("rand", a, b, c);
      release_res("rand", $urandom_range(0, 3), ref_add(a, b, c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
